// File: rtl/scm_arb_pkg.sv
// Shared types and helpers for the SCM port arbiter.
//   resp_tag_t : per-requester response bookkeeping {valid, is_write, port_idx}
//   pend_wr_t  : last cycle's SCM write {valid, addr, data}
//   next_rr    : round-robin pointer update from a one-hot "last granted" vector
// Widths are sized for the largest supported configuration; users slice down.
package scm_arb_pkg;

   localparam int unsigned MaxReq   = 8;
   localparam int unsigned PtrW     = 3;
   localparam int unsigned MaxAddrW = 16;
   localparam int unsigned MaxDataW = 64;

   typedef struct packed {
      logic            valid;
      logic            is_write;
      logic [PtrW-1:0] port_idx;
   } resp_tag_t;

   typedef struct packed {
      logic                valid;
      logic [MaxAddrW-1:0] addr;
      logic [MaxDataW-1:0] data;
   } pend_wr_t;

   // Pointer moves to one past the last granted requester, modulo n; it holds
   // when nothing was granted.
   function automatic logic [PtrW-1:0] next_rr(input logic [PtrW-1:0]   ptr,
                                               input logic [MaxReq-1:0] onehot,
                                               input int unsigned       n);
      logic [PtrW-1:0] nxt;
      nxt = ptr;
      for (int unsigned i = 0; i < MaxReq; i++) begin
         if (onehot[i]) nxt = (i + 1 >= n) ? '0 : PtrW'(i + 1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/scm_rr_pick.sv
// Cyclic first-M-of-N picker.
//   req_i  : request vector
//   ptr_i  : index where the cyclic search starts (must be < N)
//   gnt_o  : up to M granted requesters
//   last_o : one-hot of the last requester granted in search order
//   slot_o : per requester, the order (0..M-1) in which it was granted
module scm_rr_pick
   import scm_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned M = 1
) (
   input  logic [N-1:0]           req_i,
   input  logic [PtrW-1:0]        ptr_i,
   output logic [N-1:0]           gnt_o,
   output logic [N-1:0]           last_o,
   output logic [N-1:0][PtrW-1:0] slot_o
);

   always_comb begin
      int unsigned cnt;
      int unsigned pos;
      gnt_o  = '0;
      last_o = '0;
      slot_o = '0;
      cnt    = 0;
      pos    = 0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = 32'(ptr_i) + i;
         if (pos >= N) pos = pos - N;
         // Inner loop keeps every select index constant after unrolling.
         for (int unsigned j = 0; j < N; j++) begin
            if (j == pos && req_i[j] && cnt < M) begin
               gnt_o[j]  = 1'b1;
               slot_o[j] = PtrW'(cnt);
               last_o    = '0;
               last_o[j] = 1'b1;
               cnt++;
            end
         end
      end
   end

endmodule

// File: rtl/scm_port_arbiter.sv
// Round-robin arbiter sharing one latch-based SCM (1 write port, N_READ read
// ports) between N_REQ TCDM-style requesters.
//   req_i/we_i/addr_i/wdata_i : packed requester inputs
//   gnt_o                     : combinational grant
//   r_valid_o/r_rdata_o       : response one cycle after grant
//   ReadEnable/ReadAddr/ReadData, WriteEnable/WriteAddr/WriteData : SCM side
// Build option: define SCM_ARB_BYPASS_EN to serve reads that hit the current or
// previous cycle's write from a registered copy of the write data instead of
// stalling them.
module scm_port_arbiter
   import scm_arb_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned N_READ     = 2,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_i,
   input  logic [N_REQ-1:0]             we_i,
   input  logic [N_REQ*ADDR_WIDTH-1:0]  addr_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]  wdata_i,
   output logic [N_REQ-1:0]             gnt_o,
   output logic [N_REQ-1:0]             r_valid_o,
   output logic [N_REQ*DATA_WIDTH-1:0]  r_rdata_o,
   output logic [N_READ-1:0]            ReadEnable,
   output logic [N_READ*ADDR_WIDTH-1:0] ReadAddr,
   input  logic [N_READ*DATA_WIDTH-1:0] ReadData,
   output logic                         WriteEnable,
   output logic [ADDR_WIDTH-1:0]        WriteAddr,
   output logic [DATA_WIDTH-1:0]        WriteData
);

   localparam int unsigned AW = ADDR_WIDTH;
   localparam int unsigned DW = DATA_WIDTH;

   logic [N_REQ-1:0]           wr_req, rd_req_raw, rd_req;
   logic [N_REQ-1:0]           wr_gnt, rd_gnt, wr_last, rd_last;
   logic [N_REQ-1:0][PtrW-1:0] rd_slot, wr_slot_unused;
   logic [N_REQ-1:0]           hit_cur, hit_pend;
   logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]              wr_addr;
   logic [DW-1:0]              wr_data;
   pend_wr_t                   pend_q, pend_d;
   resp_tag_t [N_REQ-1:0]      tag_q, tag_d;

   assign wr_req     = req_i & we_i;
   assign rd_req_raw = req_i & ~we_i;

   scm_rr_pick #(.N(N_REQ), .M(1)) u_wr_pick (
      .req_i  (wr_req),
      .ptr_i  (wr_ptr_q),
      .gnt_o  (wr_gnt),
      .last_o (wr_last),
      .slot_o (wr_slot_unused)
   );

   scm_rr_pick #(.N(N_REQ), .M(N_READ)) u_rd_pick (
      .req_i  (rd_req),
      .ptr_i  (rd_ptr_q),
      .gnt_o  (rd_gnt),
      .last_o (rd_last),
      .slot_o (rd_slot)
   );

   // Write port mux from the single write winner.
   always_comb begin
      wr_addr = '0;
      wr_data = '0;
      for (int unsigned r = 0; r < N_REQ; r++) begin
         if (wr_gnt[r]) begin
            wr_addr = addr_i[r*AW +: AW];
            wr_data = wdata_i[r*DW +: DW];
         end
      end
   end

   assign WriteEnable = |wr_gnt;
   assign WriteAddr   = wr_addr;
   assign WriteData   = wr_data;

   // The SCM latch only settles during the cycle after WriteEnable, so reads of
   // the address written this cycle or last cycle would see stale data.
   always_comb begin
      hit_cur  = '0;
      hit_pend = '0;
      for (int unsigned r = 0; r < N_REQ; r++) begin
         hit_cur[r]  = WriteEnable && (addr_i[r*AW +: AW] == wr_addr);
         hit_pend[r] = pend_q.valid && (addr_i[r*AW +: AW] == pend_q.addr[AW-1:0]);
      end
   end

`ifdef SCM_ARB_BYPASS_EN
   logic [N_REQ-1:0]         byp_q, byp_d;
   logic [N_REQ-1:0][DW-1:0] byp_data_q, byp_data_d;

   assign rd_req = rd_req_raw;

   // Newest write wins when both the current and previous write hit.
   always_comb begin
      byp_d      = '0;
      byp_data_d = byp_data_q;
      for (int unsigned r = 0; r < N_REQ; r++) begin
         if (rd_gnt[r] && (hit_cur[r] || hit_pend[r])) begin
            byp_d[r]      = 1'b1;
            byp_data_d[r] = hit_cur[r] ? wr_data : pend_q.data[DW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_q      <= '0;
         byp_data_q <= '0;
      end else begin
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
      end
   end
`else
   assign rd_req = rd_req_raw & ~(hit_cur | hit_pend);
`endif

   // k-th granted reader drives SCM read port k.
   always_comb begin
      ReadEnable = '0;
      ReadAddr   = '0;
      for (int unsigned k = 0; k < N_READ; k++) begin
         for (int unsigned r = 0; r < N_REQ; r++) begin
            if (rd_gnt[r] && rd_slot[r] == PtrW'(k)) begin
               ReadEnable[k]          = 1'b1;
               ReadAddr[k*AW +: AW] = addr_i[r*AW +: AW];
            end
         end
      end
   end

   assign gnt_o = wr_gnt | rd_gnt;

   always_comb begin
      tag_d = '0;
      for (int unsigned r = 0; r < N_REQ; r++) begin
         tag_d[r].valid    = gnt_o[r];
         tag_d[r].is_write = we_i[r];
         tag_d[r].port_idx = rd_slot[r];
      end
   end

   assign pend_d   = '{valid: WriteEnable, addr: MaxAddrW'(wr_addr), data: MaxDataW'(wr_data)};
   assign wr_ptr_d = next_rr(wr_ptr_q, MaxReq'(wr_last), N_REQ);
   assign rd_ptr_d = next_rr(rd_ptr_q, MaxReq'(rd_last), N_REQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         pend_q   <= '0;
         tag_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         pend_q   <= pend_d;
         tag_q    <= tag_d;
      end
   end

   // Writes answer with zero data; reads pick their SCM port (or bypass copy).
   always_comb begin
      r_valid_o = '0;
      r_rdata_o = '0;
      for (int unsigned r = 0; r < N_REQ; r++) begin
         r_valid_o[r] = tag_q[r].valid;
         if (tag_q[r].valid && !tag_q[r].is_write) begin
            for (int unsigned k = 0; k < N_READ; k++) begin
               if (tag_q[r].port_idx == PtrW'(k)) r_rdata_o[r*DW +: DW] = ReadData[k*DW +: DW];
            end
`ifdef SCM_ARB_BYPASS_EN
            if (byp_q[r]) r_rdata_o[r*DW +: DW] = byp_data_q[r];
`endif
         end
      end
   end

   // Upper pend bits exist only for the widest configuration.
   logic unused_pend;
   assign unused_pend = ^pend_q;

endmodule

// File: doc/scm_port_arbiter.md
Name: scm_port_arbiter

Overview:
- Shares one latch-based SCM register file (1 write port, N_READ read ports, registered read address, clock-gated write) between N_REQ requesters.
- Requesters use a TCDM-style req/gnt/r_valid protocol.
- The block grants requests round-robin and drives the SCM ports directly.
- It blocks read-after-write hazards caused by the SCM's one-cycle write pipeline.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- N_READ, 2, SCM read ports; must match the attached register file.
- ADDR_WIDTH, 5, SCM word address width.
- DATA_WIDTH, 32, word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-requester request.
- we_i  in  N_REQ  1=write, 0=read.
- addr_i  in  N_REQ*ADDR_WIDTH  packed word addresses.
- wdata_i  in  N_REQ*DATA_WIDTH  packed write data.
- gnt_o  out  N_REQ  grant, combinational, same cycle as req.
- r_valid_o  out  N_REQ  response valid, one cycle after gnt (reads and writes).
- r_rdata_o  out  N_REQ*DATA_WIDTH  read data, valid with r_valid_o.
- ReadEnable  out  N_READ  to SCM.
- ReadAddr  out  N_READ*ADDR_WIDTH  to SCM.
- ReadData  in  N_READ*DATA_WIDTH  from SCM; valid the cycle after ReadEnable.
- WriteEnable  out  1  to SCM.
- WriteAddr  out  ADDR_WIDTH  to SCM.
- WriteData  out  DATA_WIDTH  to SCM.

Behaviour:
- Reset values: gnt_o=0, r_valid_o=0, r_rdata_o=0, both RR pointers=0, hazard registers invalid. SCM outputs are 0 while no request is active.
- Write arbitration:
  - Among requesters with req&we, pick the first at or after wr_ptr, cyclic.
  - The winner gets gnt and drives WriteEnable/WriteAddr/WriteData combinationally.
  - wr_ptr <= winner+1 mod N_REQ; unchanged when there is no winner.
- Read arbitration:
  - Among requesters with req&~we that are not hazard-blocked, grant up to N_READ, first-found order starting at rd_ptr.
  - The k-th granted requester maps to SCM read port k: ReadEnable[k]=1, ReadAddr[k]=its address.
  - rd_ptr <= last granted+1 mod N_REQ.
  - Ungranted requesters keep req asserted; no starvation is possible beyond N_REQ-1 cycles.
- Hazard: the SCM updates its latch during the cycle after WriteEnable.
  - A read whose address equals the write address granted in the current cycle (T) or in T-1 is not granted.
  - The pending-write register holds {valid, addr} of the last cycle's write.
- Response:
  - Registered per-requester tags record read/write and port index k.
  - In cycle T+1, r_valid_o is set for every requester granted in T.
  - Reads return ReadData[k]; writes return r_rdata=0.
- Simultaneous events:
  - One requester can hold at most one grant per cycle.
  - The write grant and read grants are independent except for the hazard rule.
  - Reads to the same address by two requesters may both be granted.
- Address wrap: none; full 2**ADDR_WIDTH range valid.
- Reset mid-operation: outstanding responses are dropped (r_valid_o=0). The pending-write register is cleared.

Optional Feature:
- SCM_ARB_BYPASS_EN
- Defined:
  - Reads hitting the T/T-1 pending write are granted.
  - They are served from a registered copy of the write data instead of ReadData, on the same T+1 timing.
  - A bypassed read still consumes a read-port slot, keeping the port mapping uniform.
- Undefined: the stall rule above applies.

Decomposition:
- Package scm_arb_pkg holds:
  - resp_tag_t {valid, is_write, port_idx}.
  - pend_wr_t {valid, addr, data}.
  - Function next_rr(ptr, onehot).
- Sub-module scm_rr_pick: cyclic first-M-of-N picker with pointer input. It is instantiated once with M=1 for writes and once with M=N_READ for reads.

Test Plan:
1. Reset mid-burst: assert rst_n=0 while reads are in flight -> r_valid_o=0 next cycle, gnt_o=0, pointers=0.
2. Write conflict: req0 and req2 write addr 3 (0xAAAA0000) and addr 4 (0x5555) in the same cycle -> gnt=0b0001. Next cycle req2 is granted, wr_ptr=3, then reads return the correct values.
3. Read fan-out: 4 readers, N_READ=2, addresses 1,2,3,4 -> cycle 0 grants req0/1, cycle 1 grants req2/3. Each r_valid arrives one cycle after its gnt with matching data.
4. RAW hazard: req0 writes addr 7=0xDEADBEEF in cycle T while req1 reads addr 7 in T and T+1.
   - Without macro: read granted at T+2, returns 0xDEADBEEF.
   - With SCM_ARB_BYPASS_EN: granted at T, returns 0xDEADBEEF at T+1.
5. Fairness: all 4 requesters hold continuous writes for 8 cycles -> grants rotate 0,1,2,3,0,1,2,3 with no gaps.
6. Mixed traffic: one write to addr 5 plus two reads of addr 9 in the same cycle -> all three granted, both reads return addr 9's old content.
